// File: rtl/pcie_dma_multich_sequencer.sv
// Multi-channel DMA write sequencer: turns per-channel DMABASE/DMACTRL programming into
// round-robin MWr descriptors (N payload TLPs, then one completion-token write per request).

module pcie_dma_ch #(
  parameter int TLP_QWS     = 16,
  parameter int CNT_W       = 8,
  parameter int DATA_OFFSET = 64
) (
  input  logic        clk_in,
  input  logic        rstn,
  input  logic        wr_base,
  input  logic        wr_ctrl,
  input  logic [31:0] wr_data,
  input  logic        acc,
  output logic        busy,
  output logic        err,
  output logic        done_pulse,
  output logic [31:0] base,
  output logic [31:0] next_addr,
  output logic        is_tok
);
  localparam logic [31:0] STEP = 32'(TLP_QWS * 8);

  logic [CNT_W-1:0] remain;

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      busy       <= 1'b0;
      err        <= 1'b0;
      done_pulse <= 1'b0;
      base       <= '0;
      next_addr  <= '0;
      is_tok     <= 1'b0;
      remain     <= '0;
    end else begin
      done_pulse <= 1'b0;
      // clear first so a write that also collides with busy leaves err set
      if (wr_ctrl && wr_data[31]) err <= 1'b0;
      if ((wr_base || wr_ctrl) && busy) err <= 1'b1;
      if (wr_base && !busy) base <= {wr_data[31:3], 3'b000};
      if (wr_ctrl && !busy && (wr_data[CNT_W-1:0] != '0)) begin
        busy      <= 1'b1;
        remain    <= wr_data[CNT_W-1:0];
        next_addr <= base + 32'(DATA_OFFSET);
        is_tok    <= 1'b0;
      end
      if (acc && busy) begin
        if (!is_tok) begin
          next_addr <= next_addr + STEP;
          remain    <= remain - CNT_W'(1);
          if (remain == CNT_W'(1)) is_tok <= 1'b1;
        end else begin
          busy       <= 1'b0;
          done_pulse <= 1'b1;
        end
      end
    end
  end
endmodule

module pcie_dma_multich_sequencer #(
  parameter int          NUM_CH      = 2,
  parameter int          TLP_QWS     = 16,
  parameter int          CNT_W       = 8,
  parameter int          DATA_OFFSET = 64,
  parameter logic [63:0] TOKEN       = 64'hCAFEF00DC0DEFACE,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rstn,
  input  logic              reg_wr_valid,
  input  logic [CH_W-1:0]   reg_wr_ch,
  input  logic              reg_wr_sel,
  input  logic [31:0]       reg_wr_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [31:0]       req_addr,
  output logic [6:0]        req_qws,
  output logic              req_is_token,
  output logic [63:0]       req_data,
  output logic [CH_W-1:0]   req_ch,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done_pulse,
  output logic [NUM_CH-1:0] err
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ISSUE} state_t;

  state_t                   state, state_nxt;
  logic [CH_W-1:0]          rr_ptr;
  logic [CH_W-1:0]          gnt_ch;
  logic                     gnt_ok;
  logic                     wr_hit;
  logic [NUM_CH-1:0][31:0]  ch_base, ch_next;
  logic [NUM_CH-1:0]        ch_tok;

  assign wr_hit = reg_wr_valid && (int'(reg_wr_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_base, wr_ctrl, acc;
    assign wr_base = wr_hit && !reg_wr_sel && (reg_wr_ch == CH_W'(i));
    assign wr_ctrl = wr_hit &&  reg_wr_sel && (reg_wr_ch == CH_W'(i));
    assign acc     = (state == S_ISSUE) && req_ready && (req_ch == CH_W'(i));

    pcie_dma_ch #(.TLP_QWS(TLP_QWS), .CNT_W(CNT_W), .DATA_OFFSET(DATA_OFFSET)) u_ch (
      .clk_in     (clk_in),
      .rstn       (rstn),
      .wr_base    (wr_base),
      .wr_ctrl    (wr_ctrl),
      .wr_data    (reg_wr_data),
      .acc        (acc),
      .busy       (busy[i]),
      .err        (err[i]),
      .done_pulse (done_pulse[i]),
      .base       (ch_base[i]),
      .next_addr  (ch_next[i]),
      .is_tok     (ch_tok[i])
    );
  end

  // Scan downward so the busy channel closest to rr_ptr is the last (winning) assignment
  always_comb begin
    gnt_ok = 1'b0;
    gnt_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (busy[(int'(rr_ptr) + i) % NUM_CH]) begin
        gnt_ok = 1'b1;
        gnt_ch = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|busy) state_nxt = S_GRANT;
      S_GRANT: state_nxt = gnt_ok ? S_ISSUE : S_IDLE;
      S_ISSUE: if (req_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_valid = (state == S_ISSUE);

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      req_addr     <= '0;
      req_qws      <= '0;
      req_is_token <= 1'b0;
      req_data     <= '0;
      req_ch       <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_GRANT && gnt_ok) begin
        req_ch       <= gnt_ch;
        req_is_token <= ch_tok[gnt_ch];
        req_addr     <= ch_tok[gnt_ch] ? ch_base[gnt_ch] : ch_next[gnt_ch];
        req_qws      <= ch_tok[gnt_ch] ? 7'd1 : 7'(TLP_QWS);
        req_data     <= ch_tok[gnt_ch] ? TOKEN : 64'd0;
      end
      if (state == S_ISSUE && req_ready)
        rr_ptr <= (req_ch == CH_W'(NUM_CH - 1)) ? '0 : req_ch + CH_W'(1);
    end
  end
endmodule

// File: tb/tb_pcie_dma_multich_sequencer.sv
// Scoreboard bench: register writes push expected descriptors per channel; a negedge
// monitor pops and compares every accepted descriptor and checks hold/done behaviour.

module tb_pcie_dma_multich_sequencer;
  localparam int          NUM_CH      = 2;
  localparam int          TLP_QWS     = 16;
  localparam int          CNT_W       = 8;
  localparam int          DATA_OFFSET = 64;
  localparam logic [63:0] TOKEN       = 64'hCAFEF00DC0DEFACE;
  localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [6:0]  qws;
    logic        tok;
    logic [63:0] data;
  } desc_t;

  logic              clk_in = 1'b0;
  logic              rstn;
  logic              reg_wr_valid;
  logic [CH_W-1:0]   reg_wr_ch;
  logic              reg_wr_sel;
  logic [31:0]       reg_wr_data;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [6:0]        req_qws;
  logic              req_is_token;
  logic [63:0]       req_data;
  logic [CH_W-1:0]   req_ch;
  logic [NUM_CH-1:0] busy, done_pulse, err;

  pcie_dma_multich_sequencer #(
    .NUM_CH(NUM_CH), .TLP_QWS(TLP_QWS), .CNT_W(CNT_W), .DATA_OFFSET(DATA_OFFSET), .TOKEN(TOKEN)
  ) dut (
    .clk_in(clk_in), .rstn(rstn), .reg_wr_valid(reg_wr_valid), .reg_wr_ch(reg_wr_ch),
    .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_qws(req_qws), .req_is_token(req_is_token),
    .req_data(req_data), .req_ch(req_ch), .busy(busy), .done_pulse(done_pulse), .err(err)
  );

  always #5 clk_in = ~clk_in;

  // reference model state
  desc_t             q[NUM_CH][$];
  bit                mbusy[NUM_CH];
  logic [NUM_CH-1:0] merr;
  logic [31:0]       mbase[NUM_CH];
  int                dcnt[NUM_CH];
  int                acnt[NUM_CH];
  int                gq[$];
  logic [NUM_CH-1:0] dmask;
  bit                pend;
  desc_t             held;
  logic [CH_W-1:0]   held_ch;
  bit                rand_rdy;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += q[c].size();
    return s;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete(); mbusy[c] = 0; mbase[c] = '0; dcnt[c] = 0; acnt[c] = 0;
    end
    merr = '0;
  endtask

  // Expected descriptors derived directly from the programming model
  task automatic model_wr(input int ch, input bit sel, input logic [31:0] d);
    desc_t e;
    int n;
    if (ch >= NUM_CH) return;
    if (!sel) begin
      if (mbusy[ch]) merr[ch] = 1'b1;
      else mbase[ch] = {d[31:3], 3'b000};
    end else begin
      if (d[31]) merr[ch] = 1'b0;
      if (mbusy[ch]) merr[ch] = 1'b1;
      else begin
        n = int'(d[CNT_W-1:0]);
        if (n != 0) begin
          for (int k = 0; k < n; k++) begin
            e.addr = mbase[ch] + 32'(DATA_OFFSET) + 32'(k * TLP_QWS * 8);
            e.qws = 7'(TLP_QWS); e.tok = 1'b0; e.data = 64'd0;
            q[ch].push_back(e);
          end
          e.addr = mbase[ch]; e.qws = 7'd1; e.tok = 1'b1; e.data = TOKEN;
          q[ch].push_back(e);
          mbusy[ch] = 1;
        end
      end
    end
  endtask

  task automatic wr(input int ch, input bit sel, input logic [31:0] d);
    reg_wr_valid = 1'b1; reg_wr_ch = CH_W'(ch); reg_wr_sel = sel; reg_wr_data = d;
    model_wr(ch, sel, d);
    @(posedge clk_in); #1;
    reg_wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit chk_busy0);
    int n = 0;
    bit bad = 0;
    while ((pending() != 0 || busy != '0) && n < 3000) begin
      if (chk_busy0 && q[0].size() > 0 && !busy[0]) bad = 1;
      tick(1); n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: pending=%0d busy=%0h", name, pending(), busy);
    end
    if (chk_busy0) chk({name, "_busy_throughout"}, 64'(bad), 64'd0);
  endtask

  // Monitor: descriptor scoreboard, hold-while-stalled, done pulse timing
  always @(negedge clk_in) begin : mon
    desc_t e;
    int c;
    if (!rstn) begin
      dmask = '0; pend = 0;
    end else begin
      chk("done_pulse", 64'(done_pulse), 64'(dmask));
      dmask = '0;
      for (int k = 0; k < NUM_CH; k++) if (done_pulse[k]) dcnt[k]++;
      if (pend) begin
        chk("hold_valid", 64'(req_valid), 64'd1);
        chk("hold_desc", 64'({req_addr, req_qws, req_is_token}), 64'({held.addr, held.qws, held.tok}));
        chk("hold_data", req_data, held.data);
        chk("hold_ch", 64'(req_ch), 64'(held_ch));
      end
      if (req_valid && req_ready) begin
        pend = 0;
        c = int'(req_ch);
        if (c >= NUM_CH || q[c].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_desc: ch=%0d addr=%0h", c, req_addr);
        end else begin
          e = q[c].pop_front();
          chk("desc_addr", 64'(req_addr), 64'(e.addr));
          chk("desc_qws", 64'(req_qws), 64'(e.qws));
          chk("desc_tok", 64'(req_is_token), 64'(e.tok));
          chk("desc_data", req_data, e.data);
          acnt[c]++;
          gq.push_back(c);
          if (e.tok) begin mbusy[c] = 0; dmask[c] = 1'b1; end
        end
      end else if (req_valid) begin
        pend = 1;
        held = '{addr: req_addr, qws: req_qws, tok: req_is_token, data: req_data};
        held_ch = req_ch;
      end else pend = 0;
    end
  end

  always @(posedge clk_in) if (rand_rdy) begin
    #1 req_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int n;
    bit bad;
    rand_rdy = 0;
    rstn = 1'b0; req_ready = 1'b0; reg_wr_valid = 1'b0; reg_wr_ch = '0; reg_wr_sel = 1'b0;
    reg_wr_data = '0;
    model_clear();
    tick(3);
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_busy_err_done", 64'({busy, err, done_pulse}), 64'd0);
    chk("rst_desc", 64'({req_addr, req_qws, req_is_token, req_ch}), 64'd0);
    rstn = 1'b1;
    tick(2);

    // 1: single data TLP + token, latency
    req_ready = 1'b1;
    wr(0, 0, 32'h20);
    wr(0, 1, 32'd1);
    chk("t1_busy_next", 64'(busy[0]), 64'd1);
    n = 0;
    while (!req_valid && n < 10) begin tick(1); n++; end
    chk("t1_latency", 64'(n), 64'd2);
    wait_idle("t1", 0);
    tick(2);
    chk("t1_done_count", 64'(dcnt[0]), 64'd1);

    // 2: three data TLPs, busy held until the token goes out
    wr(0, 1, 32'd3);
    wait_idle("t2", 1);
    chk("t2_busy_low", 64'(busy[0]), 64'd0);
    chk("t2_accepts", 64'(acnt[0]), 64'd6);

    // 3: two channels alternate per descriptor
    gq.delete();
    wr(0, 0, 32'h1000);
    wr(0, 1, 32'd2);
    wr(1, 0, 32'h2000);
    wr(1, 1, 32'd2);
    wait_idle("t3", 0);
    chk("t3_grants", 64'(gq.size()), 64'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++) chk("t3_grant_order", 64'(gq[i]), 64'(i % 2));

    // 4: error on writes to a busy channel, clear via bit31 with N=0
    req_ready = 1'b0;
    wr(0, 0, 32'h500);
    wr(0, 1, 32'd5);
    wr(0, 1, 32'd1);
    chk("t4_err_set", 64'(err[0]), 64'd1);
    wr(0, 1, 32'h80000001);
    chk("t4_err_clear_then_set", 64'(err[0]), 64'd1);
    wr(0, 0, 32'h700);
    req_ready = 1'b1;
    wait_idle("t4", 0);
    chk("t4_err_sticky", 64'(err[0]), 64'd1);
    wr(0, 1, 32'h80000000);
    chk("t4_err_cleared", 64'(err[0]), 64'd0);
    bad = 0;
    repeat (10) begin if (req_valid || busy != '0) bad = 1; tick(1); end
    chk("t4_no_start", 64'(bad), 64'd0);

    // 5: stall while issuing, and address wrap
    req_ready = 1'b0;
    wr(0, 0, 32'hFFFFFFC0);
    wr(0, 1, 32'd2);
    n = 0;
    while (!req_valid && n < 20) begin tick(1); n++; end
    tick(10);
    chk("t5_still_valid", 64'(req_valid), 64'd1);
    chk("t5_addr", 64'(req_addr), 64'h0);
    req_ready = 1'b1;
    wait_idle("t5", 0);

    // 6: reset mid-run abandons everything
    wr(0, 0, 32'h3000);
    wr(0, 1, 32'd4);
    n = 0;
    acnt[0] = 0;
    while (acnt[0] < 2 && n < 100) begin tick(1); n++; end
    chk("t6_reached", 64'(acnt[0]), 64'd2);
    #3 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(req_valid), 64'd0);
    chk("t6_rst_flags", 64'({busy, err, done_pulse}), 64'd0);
    chk("t6_rst_desc", 64'({req_addr, req_qws, req_is_token, req_ch}), 64'd0);
    chk("t6_rst_data", req_data, 64'd0);
    model_clear();
    tick(3);
    rstn = 1'b1;
    bad = 0;
    repeat (20) begin if (req_valid || busy != '0) bad = 1; tick(1); end
    chk("t6_quiet", 64'(bad), 64'd0);
    wr(0, 1, 32'd1);
    wait_idle("t6", 0);

    // random programming with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      int ch;
      bit sel;
      logic [31:0] d;
      ch = $urandom_range(0, NUM_CH - 1);
      sel = 1'($urandom_range(0, 1));
      if (sel) d = (($urandom_range(0, 9) == 0) ? 32'h80000000 : 32'h0) | 32'($urandom_range(0, 3));
      else d = $urandom;
      wr(ch, sel, d);
      tick($urandom_range(0, 8));
    end
    wait_idle("rand", 0);
    tick(2);
    chk("rand_err", 64'(err), 64'(merr));
    chk("rand_busy", 64'(busy), 64'd0);
    rand_rdy = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
